// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if
//   Groups the game-sequencer signals between the input front-end, the
//   datapath and the sequencer itself.
//   Player/datapath events (driven by the master side):
//     i_Frame_end    one-cycle pulse per video frame
//     i_Flap_SW      debounced flap switch level
//     i_RX_DV        UART byte valid strobe
//     i_RX_Byte[7:0] UART byte, qualified by i_RX_DV
//     i_Dead         bird collided or left the screen
//     i_Pipe_Passed  one-cycle pulse when a pipe is cleared
//   Sequencer controls (driven by the slave side, i.e. flappy_game_ctrl):
//     o_Game_Reset   one-cycle datapath reinitialise pulse
//     o_Start        high while playing
//     o_Bounce       one-cycle flap pulse to the bird FSM
//     o_Freeze       high when the datapath must hold motion
//     o_Score_Ones/o_Score_Tens  BCD score digits
//     o_State[1:0]   current game phase for debug/overlay
interface flappy_game_ctrl_if;
  logic       i_Frame_end;
  logic       i_Flap_SW;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_Dead;
  logic       i_Pipe_Passed;
  logic       o_Game_Reset;
  logic       o_Start;
  logic       o_Bounce;
  logic       o_Freeze;
  logic [3:0] o_Score_Ones;
  logic [3:0] o_Score_Tens;
  logic [1:0] o_State;

  modport master (
    output i_Frame_end, i_Flap_SW, i_RX_DV, i_RX_Byte, i_Dead, i_Pipe_Passed,
    input  o_Game_Reset, o_Start, o_Bounce, o_Freeze, o_Score_Ones,
           o_Score_Tens, o_State
  );

  modport slave (
    input  i_Frame_end, i_Flap_SW, i_RX_DV, i_RX_Byte, i_Dead, i_Pipe_Passed,
    output o_Game_Reset, o_Start, o_Bounce, o_Freeze, o_Score_Ones,
           o_Score_Tens, o_State
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
//   Top-level game sequencer. Converts switch edges and UART bytes into
//   start/bounce/reset controls, tracks the game phase and keeps a
//   saturating two-digit BCD score.
//   Ports:
//     i_Clk      system clock (pixel clock domain)
//     i_Reset_n  asynchronous active-low reset
//     bus        flappy_game_ctrl_if.slave: events in, controls/score out
module flappy_game_ctrl #(
  parameter int unsigned DEATH_FRAMES = 60,
  parameter logic [7:0]  FLAP_BYTE    = 8'h20,
  parameter logic [7:0]  RESET_BYTE   = 8'h72
) (
  input logic              i_Clk,
  input logic              i_Reset_n,
  flappy_game_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] PLAY  = 2'b01;
  localparam logic [1:0] DYING = 2'b10;
  localparam logic [1:0] OVER  = 2'b11;

  localparam logic [7:0] LAST_FRAME = 8'(DEATH_FRAMES - 1);

  logic [1:0] state;
  logic       sw_q;
  logic [7:0] death_cnt;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic       game_reset;
  logic       bounce;

  logic       flap;
  logic       rst_cmd;
  logic       score_max;

  // A flap is either a fresh switch press or a flap byte over UART.
  assign flap    = (bus.i_Flap_SW & ~sw_q) |
                   (bus.i_RX_DV & (bus.i_RX_Byte == FLAP_BYTE));
  assign rst_cmd = bus.i_RX_DV & (bus.i_RX_Byte == RESET_BYTE);
  assign score_max = (score_tens == 4'd9) && (score_ones == 4'd9);

  // Game phase, score and pulse generation. The reset byte overrides every
  // other event; pulses default low so they last exactly one cycle.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= IDLE;
      sw_q       <= 1'b0;
      death_cnt  <= 8'd0;
      score_ones <= 4'd0;
      score_tens <= 4'd0;
      game_reset <= 1'b0;
      bounce     <= 1'b0;
    end else begin
      sw_q       <= bus.i_Flap_SW;
      game_reset <= 1'b0;
      bounce     <= 1'b0;
      if (rst_cmd) begin
        state      <= IDLE;
        game_reset <= 1'b1;
        score_ones <= 4'd0;
        score_tens <= 4'd0;
        death_cnt  <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            // The starting flap only launches the game, it does not bounce.
            if (flap) begin
              state      <= PLAY;
              game_reset <= 1'b1;
              score_ones <= 4'd0;
              score_tens <= 4'd0;
            end
          end
          PLAY: begin
            // A pipe cleared on the fatal cycle still counts.
            if (bus.i_Pipe_Passed && !score_max) begin
              if (score_ones == 4'd9) begin
                score_ones <= 4'd0;
                score_tens <= score_tens + 4'd1;
              end else begin
                score_ones <= score_ones + 4'd1;
              end
            end
            if (bus.i_Dead) begin
              state     <= DYING;
              death_cnt <= 8'd0;
            end else if (flap) begin
              bounce <= 1'b1;
            end
          end
          DYING: begin
            if (bus.i_Frame_end) begin
              if (death_cnt == LAST_FRAME)
                state <= OVER;
              if (death_cnt != 8'hFF)
                death_cnt <= death_cnt + 8'd1;
            end
          end
          default: begin
            // Score stays visible on the idle screen until the next start.
            if (flap) begin
              state      <= IDLE;
              game_reset <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.o_Game_Reset = game_reset;
  assign bus.o_Bounce     = bounce;
  assign bus.o_Start      = (state == PLAY);
  assign bus.o_Freeze     = (state != PLAY);
  assign bus.o_State      = state;
  assign bus.o_Score_Ones = score_ones;
  assign bus.o_Score_Tens = score_tens;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
module tb_flappy_game_ctrl;

  localparam int DF = 3;

  logic i_Clk;
  logic i_Reset_n;

  flappy_game_ctrl_if bus ();

  flappy_game_ctrl #(
    .DEATH_FRAMES(DF),
    .FLAP_BYTE(8'h20),
    .RESET_BYTE(8'h72)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset_n(i_Reset_n),
    .bus(bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: game phase as a name-level integer, score as a plain
  // integer 0..99, frames seen while dying.
  int m_phase;
  int m_score;
  int m_frames;
  bit m_sw_prev;
  bit m_reset;
  bit m_bounce;

  typedef struct {
    logic       sw;
    logic       dv;
    logic [7:0] rx_byte;
    logic       dead;
    logic       pipe;
    logic       frame;
    logic [1:0] exp_state;
    logic       exp_reset;
    logic       exp_bounce;
    int         exp_score;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic sw, logic dv, logic [7:0] b, logic dead,
                              logic pipe, logic frame, logic [1:0] st,
                              logic rs, logic bo, int sc);
    vec_t v;
    v.sw = sw; v.dv = dv; v.rx_byte = b; v.dead = dead; v.pipe = pipe;
    v.frame = frame; v.exp_state = st; v.exp_reset = rs; v.exp_bounce = bo;
    v.exp_score = sc;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_frames = 0; m_sw_prev = 0;
    m_reset = 0; m_bounce = 0;
  endtask

  task automatic model_step(input logic sw, input logic dv,
                            input logic [7:0] b, input logic dead,
                            input logic pipe, input logic frame);
    bit flap;
    bit rcmd;
    flap = (sw && !m_sw_prev) || (dv && b == 8'h20);
    rcmd = dv && b == 8'h72;
    m_sw_prev = sw;
    m_reset = 0;
    m_bounce = 0;
    if (rcmd) begin
      m_phase = 0; m_reset = 1; m_score = 0; m_frames = 0;
    end else if (m_phase == 0) begin
      if (flap) begin m_phase = 1; m_reset = 1; m_score = 0; end
    end else if (m_phase == 1) begin
      if (pipe && m_score < 99) m_score = m_score + 1;
      if (dead) begin m_phase = 2; m_frames = 0; end
      else if (flap) m_bounce = 1;
    end else if (m_phase == 2) begin
      if (frame) begin
        m_frames = m_frames + 1;
        if (m_frames >= DF) m_phase = 3;
      end
    end else begin
      if (flap) begin m_phase = 0; m_reset = 1; end
    end
  endtask

  // Drives one cycle of inputs at a falling edge and advances the model;
  // returns at the next falling edge, where outputs are stable.
  task automatic applyStimulus(input logic sw, input logic dv,
                               input logic [7:0] b, input logic dead,
                               input logic pipe, input logic frame);
    bus.i_Flap_SW = sw;
    bus.i_RX_DV = dv;
    bus.i_RX_Byte = b;
    bus.i_Dead = dead;
    bus.i_Pipe_Passed = pipe;
    bus.i_Frame_end = frame;
    model_step(sw, dv, b, dead, pipe, frame);
    @(negedge i_Clk);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] st,
                             input logic rs, input logic bo, input int sc);
    logic [14:0] got;
    logic [14:0] exp;
    logic [3:0]  e_tens;
    logic [3:0]  e_ones;
    e_tens = 4'(sc / 10);
    e_ones = 4'(sc % 10);
    got = {bus.o_State, bus.o_Game_Reset, bus.o_Bounce, bus.o_Start,
           bus.o_Freeze, bus.o_Score_Tens, bus.o_Score_Ones};
    exp = {st, rs, bo, (st == 2'b01), (st != 2'b01), e_tens, e_ones};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got state=%b rst=%b bnc=%b start=%b frz=%b score=%h%h, want state=%b rst=%b bnc=%b start=%b frz=%b score=%h%h",
               name, got[14:13], got[12], got[11], got[10], got[9], got[7:4],
               got[3:0], exp[14:13], exp[12], exp[11], exp[10], exp[9],
               exp[7:4], exp[3:0]);
    end
  endtask

  task automatic check_model(input string name);
    checkOutput(name, 2'(m_phase), m_reset, m_bounce, m_score);
  endtask

  initial begin
    i_Reset_n = 1'b0;
    bus.i_Flap_SW = 0; bus.i_RX_DV = 0; bus.i_RX_Byte = 8'h00;
    bus.i_Dead = 0; bus.i_Pipe_Passed = 0; bus.i_Frame_end = 0;
    model_reset();

    vecs[0]  = mk(0,0,8'h00,0,0,0, 2'b00,0,0,0);
    vecs[1]  = mk(1,0,8'h00,0,0,0, 2'b01,1,0,0);
    vecs[2]  = mk(1,0,8'h00,0,0,0, 2'b01,0,0,0);
    vecs[3]  = mk(0,1,8'h20,0,0,0, 2'b01,0,1,0);
    vecs[4]  = mk(0,0,8'h00,0,1,0, 2'b01,0,0,1);
    vecs[5]  = mk(0,1,8'h41,0,0,0, 2'b01,0,0,1);
    vecs[6]  = mk(0,1,8'h20,1,1,0, 2'b10,0,0,2);
    vecs[7]  = mk(0,0,8'h00,0,0,1, 2'b10,0,0,2);
    vecs[8]  = mk(1,0,8'h00,0,1,1, 2'b10,0,0,2);
    vecs[9]  = mk(0,0,8'h00,0,0,1, 2'b11,0,0,2);
    vecs[10] = mk(0,0,8'h00,0,1,0, 2'b11,0,0,2);
    vecs[11] = mk(0,1,8'h41,0,0,0, 2'b11,0,0,2);
    vecs[12] = mk(1,0,8'h00,0,0,0, 2'b00,1,0,2);
    vecs[13] = mk(0,1,8'h72,0,0,0, 2'b00,1,0,0);
    vecs[14] = mk(0,1,8'h41,0,0,0, 2'b00,0,0,0);

    repeat (2) @(negedge i_Clk);
    checkOutput("reset_state", 2'b00, 0, 0, 0);
    i_Reset_n = 1'b1;

    // Directed table: start, bounce, scoring, death, over, reset byte.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].sw, vecs[i].dv, vecs[i].rx_byte, vecs[i].dead,
                    vecs[i].pipe, vecs[i].frame);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_state,
                  vecs[i].exp_reset, vecs[i].exp_bounce, vecs[i].exp_score);
    end

    // Held switch across 100 cycles fires only the one start flap.
    applyStimulus(1,0,8'h00,0,0,0);
    checkOutput("held_start", 2'b01, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1,0,8'h00,0,0,0);
      checkOutput("held_no_refire", 2'b01, 0, 0, 0);
    end

    // BCD carry 09 -> 10, then saturation at 99.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1,0,8'h00,0,1,0);
      checkOutput("bcd_count", 2'b01, 0, 0, i);
    end
    for (int i = 11; i <= 98; i++) applyStimulus(1,0,8'h00,0,1,0);
    checkOutput("score_98", 2'b01, 0, 0, 98);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,8'h00,0,1,0);
      checkOutput("score_sat", 2'b01, 0, 0, 99);
    end

    // Reset byte from PLAY.
    applyStimulus(0,1,8'h72,1,1,0);
    checkOutput("rstcmd_play", 2'b00, 1, 0, 0);

    // Asynchronous reset mid-PLAY with score 07, checked before any edge.
    applyStimulus(0,1,8'h20,0,0,0);
    for (int i = 0; i < 7; i++) applyStimulus(0,0,8'h00,0,1,0);
    checkOutput("pre_async", 2'b01, 0, 0, 7);
    #2;
    i_Reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 2'b00, 0, 0, 0);
    model_reset();
    @(negedge i_Clk);
    i_Reset_n = 1'b1;

    // Randomised run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic sw, dv, dead, pipe, frame;
      logic [7:0] b;
      int r;
      sw = ($urandom_range(0, 7) == 0) ? ~bus.i_Flap_SW : bus.i_Flap_SW;
      r = $urandom_range(0, 99);
      dv = ($urandom_range(0, 5) == 0);
      b = (r < 3) ? 8'h72 : (r < 30) ? 8'h20 : 8'($urandom);
      dead = ($urandom_range(0, 24) == 0);
      pipe = ($urandom_range(0, 3) == 0);
      frame = ($urandom_range(0, 2) == 0);
      applyStimulus(sw, dv, b, dead, pipe, frame);
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Top-level game sequencer for the Flappy Bird datapath.
- Turns player inputs (debounced Switch level, UART RX bytes) into clean start/bounce/reset controls for the bird controller and pipe logic.
- Tracks the game phase and keeps a saturating 2-digit BCD score for the 7-segment displays.
- Sits between the input front-end (Debounce_Filter, UART_RX) and the datapath (bird FSM, pipe generator, frame_counter).

Parameters:
DEATH_FRAMES, 60, number of i_Frame_end pulses spent in DYING before OVER (legal range 1..255)
FLAP_BYTE, 8'h20, UART byte treated as a flap (ASCII space)
RESET_BYTE, 8'h72, UART byte forcing a game reset (ASCII 'r')

Ports:
i_Clk  in  1  system clock, 25 MHz pixel clock domain
i_Reset_n  in  1  asynchronous active-low reset
i_Frame_end  in  1  one-cycle pulse per video frame from frame_counter
i_Flap_SW  in  1  debounced switch level; a rising edge is a flap
i_RX_DV  in  1  one-cycle valid strobe from UART_RX
i_RX_Byte  in  8  received byte, qualified by i_RX_DV
i_Dead  in  1  level from bird FSM: collision or out of bounds
i_Pipe_Passed  in  1  one-cycle pulse when the bird clears a pipe
o_Game_Reset  out  1  one-cycle pulse that reinitialises the datapath
o_Start  out  1  high while in PLAY
o_Bounce  out  1  one-cycle flap pulse to the bird FSM
o_Freeze  out  1  high when the datapath must hold motion
o_Score_Ones  out  4  BCD ones digit
o_Score_Tens  out  4  BCD tens digit
o_State  out  2  current state encoding, for debug/overlay

Behaviour:
- All state is registered on rising i_Clk. i_Reset_n low clears it immediately, regardless of the clock.
- Reset values: state IDLE, o_Game_Reset 0, o_Start 0, o_Bounce 0, o_Freeze 1, score 00, death counter 0, switch edge register 0.
- Events, decoded combinationally and acted on at the same clock edge:
  - flap = (i_Flap_SW & ~sw_q) | (i_RX_DV & i_RX_Byte==FLAP_BYTE).
  - rst_cmd = i_RX_DV & i_RX_Byte==RESET_BYTE.
  - sw_q is i_Flap_SW delayed one cycle.
- State encoding: IDLE=00, PLAY=01, DYING=10, OVER=11.
- Latency: an event sampled at edge n produces its state change and output pulse visible after edge n. Pulses last exactly one cycle.
- rst_cmd in any state has highest priority:
  - next state IDLE, o_Game_Reset=1 for one cycle, score cleared, death counter cleared.
  - Any flap, dead or pipe event in the same cycle is ignored.
- IDLE:
  - flap -> PLAY, o_Game_Reset=1 for one cycle, score cleared to 00.
  - No o_Bounce on the starting flap.
- PLAY:
  - flap -> o_Bounce=1 for one cycle.
  - i_Pipe_Passed -> score +1 in BCD: ones 9 wraps to 0 and carries into tens; saturates at 99 with no wrap.
  - i_Dead=1 -> DYING, death counter cleared.
  - Dead and flap in the same cycle: no bounce.
  - Dead and pipe pulse in the same cycle: score still increments.
- DYING:
  - Flaps and pipe pulses are ignored.
  - Counter increments on each i_Frame_end.
  - When i_Frame_end arrives with counter==DEATH_FRAMES-1 -> OVER.
- OVER:
  - Score is held.
  - flap -> IDLE with o_Game_Reset=1 for one cycle. Score is retained until the next IDLE->PLAY transition.
- Outputs:
  - o_Start = (state==PLAY).
  - o_Freeze = (state!=PLAY).
  - o_State = state.
  - All outputs are registered; none is a combinational path from any input.
- i_Dead is ignored outside PLAY.
- A held switch produces only one flap. sw_q tracks the switch in every state, so a level held across a state change does not refire.
- Counter width is 8 bits; it saturates rather than wraps.

Test Plan:
1. Reset low mid-PLAY with score 07 -> outputs immediately return to IDLE values (o_Freeze=1, score 00, o_State=00) before the next clock edge.
2. IDLE, pulse i_Flap_SW 0->1 -> one-cycle o_Game_Reset, o_State=01, o_Start=1, o_Bounce stays 0. Hold the switch high 100 cycles -> no further pulses. Send RX byte 8'h20 -> o_Bounce=1 for exactly one cycle.
3. PLAY, score 09, one i_Pipe_Passed -> 10 (Tens=1, Ones=0). From 98, three pulses -> 99 held.
4. PLAY, i_Dead=1 together with i_Pipe_Passed and an RX 8'h20 flap, DEATH_FRAMES=3 -> score +1, no o_Bounce, state 10. After the 3rd i_Frame_end -> state 11. Flap in OVER -> o_Game_Reset pulse and IDLE with score retained.
5. In DYING, RX byte 8'h72 -> IDLE, o_Game_Reset pulse, score 00. The same byte in IDLE and PLAY gives the same result.
6. RX byte 8'h41 with i_RX_DV high in every state -> no state change and no pulses.
